// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, downstream redirect,
// and the decode handshake carrying the held instruction and its control fields.
interface instr_fetch_unit_if;
   localparam int unsigned XLEN = 32;
   localparam int unsigned FW   = 6;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            ins_valid;
   logic            ins_ready;
   logic [XLEN-1:0] ins_word;
   logic [XLEN-1:0] ins_pc;
   logic [FW-1:0]   opcode;
   logic [FW-1:0]   func;

   modport master (
      output imem_req, imem_addr,
      input  imem_ready, imem_rvalid, imem_rdata,
      input  redirect, redirect_pc,
      output ins_valid,
      input  ins_ready,
      output ins_word, ins_pc, opcode, func
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ready, imem_rvalid, imem_rdata,
      output redirect, redirect_pc,
      input  ins_valid,
      output ins_ready,
      input  ins_word, ins_pc, opcode, func
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch: owns the PC, keeps one memory request in flight,
// holds the returned word for decode and squashes stale fetches on redirect.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic             clk,
   input logic             reset,
   instr_fetch_unit_if.master bus
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] word_q;
   logic [XLEN-1:0] word_pc_q;
   logic [XLEN-1:0] redirect_tgt;
   logic            capture;

   assign redirect_tgt = XLEN'(bus.redirect_pc & ~32'd3);
   // Only non-squashed data returned in WAIT becomes the held instruction.
   assign capture      = (state == WAIT) && bus.imem_rvalid && !bus.redirect;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; redirect outranks every normal transition
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  state_nxt = REQ;
         REQ: begin
            if (bus.imem_ready) state_nxt = bus.redirect ? DRAIN : WAIT;
            else                state_nxt = REQ;
         end
         WAIT: begin
            if (bus.imem_rvalid)   state_nxt = bus.redirect ? REQ : HOLD;
            else if (bus.redirect) state_nxt = DRAIN;
         end
         HOLD: begin
            if (bus.redirect || bus.ins_ready) state_nxt = REQ;
         end
         DRAIN: begin
            if (bus.imem_rvalid) state_nxt = REQ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // PC and held-instruction registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pc        <= XLEN'(RESET_PC & ~32'd3);
         word_q    <= '0;
         word_pc_q <= '0;
      end else begin
         if (bus.redirect)  pc <= redirect_tgt;
         else if (capture)  pc <= pc + XLEN'(4);
         if (capture) begin
            word_q    <= bus.imem_rdata;
            word_pc_q <= pc;
         end
      end
   end

   // Output decode; ins_valid drops combinationally in a redirect cycle
   always_comb begin
      bus.imem_req  = 1'b0;
      bus.imem_addr = pc;
      bus.ins_valid = 1'b0;
      bus.ins_word  = word_q;
      bus.ins_pc    = word_pc_q;
      bus.opcode    = word_q[31:26];
      bus.func      = word_q[5:0];
      if (state == REQ)  bus.imem_req  = 1'b1;
      if (state == HOLD) bus.ins_valid = !bus.redirect;
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: transaction-level scoreboard checked every
// cycle, plus literal expectations for the main scenarios and a wrap-around instance.
module tb_instr_fetch_unit;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_fetch_unit_if bus();
   instr_fetch_unit_if wbus();

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (.clk(clk), .reset(reset), .bus(bus));
   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (.clk(clk), .reset(reset), .bus(wbus));

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory model for the main instance: data = address ^ mask, programmable latency
   logic        mem_rdy;
   int          mem_lat;
   logic [31:0] mem_mask;
   logic        mem_force;
   assign bus.imem_ready = mem_rdy;

   initial begin
      bit          pend;
      int          cnt;
      logic [31:0] paddr;
      pend = 0; cnt = 0; paddr = '0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      forever begin
         @(posedge clk);
         if (reset) pend = 0;
         else begin
            if (bus.imem_rvalid) pend = 0;
            if (bus.imem_req && bus.imem_ready) begin
               pend = 1; cnt = mem_lat; paddr = bus.imem_addr;
            end
         end
         #1;
         bus.imem_rvalid = 1'b0;
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               bus.imem_rvalid = 1'b1;
               bus.imem_rdata  = mem_force ? 32'hDEAD_BEEF : (paddr ^ mem_mask);
            end
         end
      end
   end

   // Single-cycle memory returning word = address for the wrap instance
   initial begin
      logic        wacc;
      logic [31:0] waddr;
      wbus.imem_rvalid = 1'b0; wbus.imem_rdata = '0; wbus.imem_ready = 1'b1;
      wbus.redirect = 1'b0; wbus.redirect_pc = '0; wbus.ins_ready = 1'b1;
      forever begin
         @(posedge clk);
         wacc  = wbus.imem_req && wbus.imem_ready && !reset;
         waddr = wbus.imem_addr;
         #1;
         wbus.imem_rvalid = wacc;
         wbus.imem_rdata  = waddr;
      end
   end

   // Scoreboard: expected fetch PC, outstanding request, and instructions owed to decode
   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_pc;
   bit          m_out, m_stale, m_idle, chk_en;
   int          acc_cnt = 0;

   initial begin
      m_pc = '0; m_out = 0; m_stale = 0; m_idle = 1; chk_en = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            m_pc = 32'h0; m_out = 0; m_stale = 0; m_idle = 1; q.delete();
         end else if (chk_en) begin
            logic [31:0] w;
            bit          exp_valid, exp_req;
            exp_valid = (q.size() != 0) && !bus.redirect;
            exp_req   = !m_idle && !m_out && (q.size() == 0);
            chk("sb_ins_valid", 32'(bus.ins_valid), 32'(exp_valid));
            chk("sb_imem_req", 32'(bus.imem_req), 32'(exp_req));
            chk("sb_imem_addr", bus.imem_addr, m_pc);
            if (bus.ins_valid && q.size() != 0) begin
               w = q[0].word;
               chk("sb_ins_pc", bus.ins_pc, q[0].pc);
               chk("sb_ins_word", bus.ins_word, w);
               chk("sb_opcode", 32'(bus.opcode), 32'(w[31:26]));
               chk("sb_func", 32'(bus.func), 32'(w[5:0]));
            end
            if (bus.imem_rvalid && m_out) begin
               if (!m_stale && !bus.redirect) begin
                  q.push_back('{pc: m_pc, word: bus.imem_rdata});
                  m_pc = m_pc + 32'd4;
               end
               m_out = 0; m_stale = 0;
            end
            if (bus.ins_valid && bus.ins_ready && q.size() != 0) void'(q.pop_front());
            if (bus.imem_req && bus.imem_ready) begin
               m_out = 1; m_stale = bus.redirect; acc_cnt++;
            end
            if (bus.redirect) begin
               m_pc = bus.redirect_pc & ~32'd3;
               q.delete();
               if (m_out) m_stale = 1;
            end
            m_idle = 0;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int acc0;
      reset = 1'b1;
      bus.redirect = 1'b0; bus.redirect_pc = '0; bus.ins_ready = 1'b0;
      mem_rdy = 1'b1; mem_lat = 1; mem_mask = '0; mem_force = 1'b0;
      cyc(2);
      // cycle 0: first cycle after reset sampled
      reset = 1'b0; chk_en = 1; bus.ins_ready = 1'b1;
      chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
      chk("rst_ins_valid", 32'(bus.ins_valid), 32'd0);
      chk("rst_imem_addr", bus.imem_addr, 32'h0);
      chk("rst_ins_word", bus.ins_word, 32'h0);
      chk("rst_ins_pc", bus.ins_pc, 32'h0);
      chk("rst_opcode_func", {20'h0, bus.opcode, bus.func}, 32'h0);
      chk("wrap_rst_addr", wbus.imem_addr, 32'hFFFF_FFFC);
      cyc(1); // cycle 1
      chk("run_req_c1", 32'(bus.imem_req), 32'd1);
      chk("wrap_addr_c1", wbus.imem_addr, 32'hFFFF_FFFC);
      cyc(2); // cycle 3
      chk("run_valid_c3", 32'(bus.ins_valid), 32'd1);
      chk("run_pc_c3", bus.ins_pc, 32'h0);
      chk("wrap_pc_c3", wbus.ins_pc, 32'hFFFF_FFFC);
      chk("wrap_opc_c3", {20'h0, wbus.opcode, wbus.func}, {20'h0, 6'h3F, 6'h3C});
      cyc(1); // cycle 4
      chk("run_valid_c4", 32'(bus.ins_valid), 32'd0);
      chk("run_addr_c4", bus.imem_addr, 32'h4);
      chk("wrap_req_c4", 32'(wbus.imem_req), 32'd1);
      chk("wrap_addr_c4", wbus.imem_addr, 32'h0);
      cyc(2); // cycle 6
      chk("run_word_c6", bus.ins_word, 32'h4);
      chk("wrap_pc_c6", wbus.ins_pc, 32'h0);
      cyc(3); // cycle 9
      chk("run_valid_c9", 32'(bus.ins_valid), 32'd1);
      chk("run_word_c9", bus.ins_word, 32'h8);
      chk("run_func_c9", 32'(bus.func), 32'h8);
      mem_mask = 32'h8C00_0021;
      cyc(3); // cycle 12: HOLD at pc 12, back-pressure starts
      bus.ins_ready = 1'b0;
      chk("bp_word", bus.ins_word, 32'h8C00_002D);
      chk("bp_opcode", 32'(bus.opcode), 32'h23);
      chk("bp_func", 32'(bus.func), 32'h2D);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid_held", 32'(bus.ins_valid), 32'd1);
         chk("bp_no_req", 32'(bus.imem_req), 32'd0);
         chk("bp_pc_held", bus.ins_pc, 32'hC);
         cyc(1);
      end
      // cycle 17: release decode, stall memory for the next request
      bus.ins_ready = 1'b1; mem_rdy = 1'b0;
      chk("bp_addr_before_release", bus.imem_addr, 32'h10);
      cyc(1); // cycle 18
      acc0 = acc_cnt;
      for (int i = 0; i < 4; i++) begin
         chk("stall_req", 32'(bus.imem_req), 32'd1);
         chk("stall_addr", bus.imem_addr, 32'h10);
         cyc(1);
      end
      mem_rdy = 1'b1; // cycle 22
      cyc(2); // cycle 24: HOLD
      chk("stall_one_accept", 32'(acc_cnt - acc0), 32'd1);
      chk("stall_pc", bus.ins_pc, 32'h10);
      chk("stall_word", bus.ins_word, 32'h8C00_0031);
      mem_lat = 3;
      cyc(2); // cycle 26: WAIT at 0x14, response not yet back
      bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0100; mem_force = 1'b1;
      cyc(1); // cycle 27: DRAIN
      bus.redirect = 1'b0;
      chk("drain_no_req", 32'(bus.imem_req), 32'd0);
      chk("drain_addr", bus.imem_addr, 32'h100);
      cyc(1); // cycle 28: stale DEAD_BEEF arrives
      mem_lat = 1;
      chk("drain_no_valid", 32'(bus.ins_valid), 32'd0);
      cyc(1); // cycle 29
      mem_force = 1'b0;
      chk("redir_req", 32'(bus.imem_req), 32'd1);
      chk("redir_addr", bus.imem_addr, 32'h100);
      cyc(2); // cycle 31: HOLD at 0x100
      chk("redir_pc", bus.ins_pc, 32'h100);
      chk("redir_word", bus.ins_word, 32'h8C00_0121);
      bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0203;
      #1;
      chk("hold_redir_valid", 32'(bus.ins_valid), 32'd0);
      cyc(1); // cycle 32
      bus.redirect = 1'b0;
      chk("hold_redir_addr", bus.imem_addr, 32'h200);
      cyc(2); // cycle 34
      chk("hold_redir_pc", bus.ins_pc, 32'h200);
      mem_lat = 3;
      cyc(2); // cycle 36: WAIT at 0x204
      bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0400;
      cyc(1); // cycle 37: DRAIN with request outstanding
      bus.redirect = 1'b0; reset = 1'b1;
      chk("pre_rst_addr", bus.imem_addr, 32'h400);
      cyc(1); // cycle 38: reset applied
      reset = 1'b0; mem_lat = 1;
      chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
      chk("mid_rst_valid", 32'(bus.ins_valid), 32'd0);
      chk("mid_rst_addr", bus.imem_addr, 32'h0);
      chk("mid_rst_word", bus.ins_word, 32'h0);
      chk("mid_rst_pc", bus.ins_pc, 32'h0);
      chk("mid_rst_opc", {20'h0, bus.opcode, bus.func}, 32'h0);
      cyc(3); // cycle 41
      chk("post_rst_valid", 32'(bus.ins_valid), 32'd1);
      chk("post_rst_word", bus.ins_word, 32'h8C00_0021);
      cyc(6);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
